char_demux9: RTL and testbench
==============================

// Module: char_demux9
// PURPOSE
//  Steers a stream of 8-bit Enigma characters to one of two consumers:
//  A = lamp/display path, B = serial TX path. Per-character destination tag.
//  Inverse of the 2:1 {flag,byte} select at the rotor-core input.
//  Small in-order FIFO between core and consumers absorbs backpressure.
//  Consumers use valid/ready; a stalled head blocks both destinations.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >=2
//  CHAR_W  8   character width (from package; do not override per instance)
// PORTS
//  clk       in   1       single clock, rising edge
//  rst       in   1       asynchronous, active-high reset
//  in_valid  in   1       core presents a character
//  in_sel    in   1       destination tag: 0=A, 1=B; sampled with in_data
//  in_data   in   CHAR_W  character code
//  in_ready  out  1       FIFO can accept (not full)
//  a_valid   out  1       head entry is valid and tagged A
//  a_data    out  CHAR_W  head data when a_valid, else 0
//  a_ready   in   1       consumer A accepts
//  b_valid   out  1       head entry is valid and tagged B
//  b_data    out  CHAR_W  head data when b_valid, else 0
//  b_ready   in   1       consumer B accepts
//  level     out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (async assert, sync release): wr/rd ptrs=0, level=0, in_ready=1,
//    a_valid=b_valid=0, a_data=b_data=0; FIFO contents don't-care.
//  - Push: in_valid & in_ready -> store {in_sel,in_data} at wr_ptr, wr_ptr++.
//  - Pop: (a_valid & a_ready) | (b_valid & b_ready) -> rd_ptr++.
//  - Latency: char accepted in cycle N is visible at output in cycle N+1
//    when FIFO was empty; no same-cycle bypass.
//  - Ordering: strict arrival order across both destinations; B-tagged head
//    with b_ready=0 stalls a following A-tagged entry (no reordering).
//  - in_ready = (level != DEPTH); a pop in the same cycle does NOT raise
//    in_ready while full (no full-cycle pass-through).
//  - Simultaneous push+pop when 0<level<DEPTH: level unchanged, both ptrs advance.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; level derived
//    from a separate counter, never from pointer difference alone.
//  - Outputs: valid/data are combinational from the head register and level.
//    Non-selected side drives valid=0, data=0.
//  - Ready without valid is ignored; in_valid while full is ignored (char
//    must be held by core, per handshake).
//  - Reset mid-stream discards all buffered characters; no partial output.
// CONFIGURATION
//  DEMUX_STATS_EN defined: adds outputs cnt_a, cnt_b (16 bit each) counting
//    pops to A/B; cleared by rst; saturate at 16'hFFFF; plus drop_cnt (8 bit,
//    saturating) counting cycles with in_valid & !in_ready.
//  Not defined: those ports and counters do not exist; core logic identical.
// STRUCTURE
//  enigma_pkg: CHAR_W=8, DEST_A=1'b0, DEST_B=1'b1, typedef for {sel,char}
//    entry (9 bits), shared with the core-side input select.
//  Sub-module char_fifo (DEPTH, width 9): storage, ptrs, level, full/empty.
//  Top char_demux9: head decode, per-side valid/data gating, pop logic, stats.
// TESTING
//  1 Reset: rst=1 mid-run with level=3 -> level=0, in_ready=1, all valid/data 0.
//  2 Single char: push 'H'(8'h48) sel=0, a_ready=1 -> a_valid=1,a_data=8'h48
//    next cycle for 1 cycle; b_valid stays 0.
//  3 Fill: a_ready=b_ready=0, push 5 chars -> in_ready=0 after 4th, 5th held,
//    level=4; release -> 4 chars out in order, then 5th.
//  4 HOL block: push B:'X' then A:'Y', b_ready=0,a_ready=1 -> a_valid=0 until
//    b_ready=1; 'X' out on B, 'Y' on A next cycle.
//  5 Steady stream: alternating sel, both ready=1, push every cycle for 20
//    cycles -> level<=1, each char once on correct side, ptr wrap exercised.
//  6 DEMUX_STATS_EN: 3 A pops, 2 B pops, 4 full-stall cycles -> cnt_a=3,
//    cnt_b=2, drop_cnt=4; build without macro compiles with no stats ports.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared character types for the Enigma datapath: the {dest, char} entry used
// by the core-side input select and by the output demux.
package enigma_pkg;
    localparam int CHAR_W = 8;
    localparam logic DEST_A = 1'b0;
    localparam logic DEST_B = 1'b1;

    typedef struct packed {
        logic              sel;
        logic [CHAR_W-1:0] chr;
    } char_entry_t;

    localparam int ENTRY_W = $bits(char_entry_t);
endpackage

// File: rtl/char_fifo.sv
// In-order FIFO of tagged characters: storage, wrapping pointers and a separate
// occupancy counter. Push while full and pop while empty are ignored.
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Contents need no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/char_demux9.sv
// Steers buffered Enigma characters to the lamp (A) or serial TX (B) consumer
// in strict arrival order. Optional counters enabled by DEMUX_STATS_EN.
module char_demux9
    import enigma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sel,
    input  logic [CHAR_W-1:0]      in_data,
    output logic                   in_ready,
    output logic                   a_valid,
    output logic [CHAR_W-1:0]      a_data,
    input  logic                   a_ready,
    output logic                   b_valid,
    output logic [CHAR_W-1:0]      b_data,
    input  logic                   b_ready,
    output logic [$clog2(DEPTH):0] level
`ifdef DEMUX_STATS_EN
    ,
    output logic [15:0]            cnt_a,
    output logic [15:0]            cnt_b,
    output logic [7:0]             drop_cnt
`endif
);
    char_entry_t head, wr_entry;
    logic        full, empty, push, pop_a, pop_b;

    assign wr_entry = '{sel: in_sel, chr: in_data};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    char_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop_a || pop_b),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // Only the head is ever presented, so a stalled head blocks both sides.
    assign a_valid = !empty && (head.sel == DEST_A);
    assign b_valid = !empty && (head.sel == DEST_B);
    assign a_data  = a_valid ? head.chr : '0;
    assign b_data  = b_valid ? head.chr : '0;
    assign pop_a   = a_valid && a_ready;
    assign pop_b   = b_valid && b_ready;

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt_a_q, cnt_b_q;
    logic [7:0]  drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            drop_q  <= '0;
        end else begin
            if (pop_a && cnt_a_q != 16'hFFFF)           cnt_a_q <= cnt_a_q + 16'd1;
            if (pop_b && cnt_b_q != 16'hFFFF)           cnt_b_q <= cnt_b_q + 16'd1;
            if (in_valid && !in_ready && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    assign cnt_a    = cnt_a_q;
    assign cnt_b    = cnt_b_q;
    assign drop_cnt = drop_q;
`endif
endmodule

// File: tb/tb_char_demux9.sv
// Directed bench for char_demux9: a queue model checked every cycle plus
// hand-computed expectations for reset, latency, fill, head blocking and streaming.
module tb_char_demux9;
    import enigma_pkg::*;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_sel = 1'b0, a_ready = 1'b0, b_ready = 1'b0;
    logic [7:0] in_data = '0;
    logic in_ready, a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [2:0] level;
`ifdef DEMUX_STATS_EN
    logic [15:0] cnt_a, cnt_b;
    logic [7:0]  drop_cnt;
`endif

    char_demux9 #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .level(level)
`ifdef DEMUX_STATS_EN
        , .cnt_a(cnt_a), .cnt_b(cnt_b), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain queue of {dest,char} in arrival order plus event counts.
    bit [8:0] mq[$];
    int m_pop_a = 0, m_pop_b = 0, m_drop = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_pop_a = 0; m_pop_b = 0; m_drop = 0;
        end else begin
            bit can_push, do_pop;
            can_push = (mq.size() < DEPTH);
            do_pop = 1'b0;
            if (mq.size() > 0) begin
                if (!mq[0][8] && a_ready) begin do_pop = 1'b1; m_pop_a++; end
                if ( mq[0][8] && b_ready) begin do_pop = 1'b1; m_pop_b++; end
            end
            if (in_valid && !can_push) m_drop++;
            if (do_pop) void'(mq.pop_front());
            if (in_valid && can_push) mq.push_back({in_sel, in_data});
        end
    end

    // DUT-observed deliveries, for the streaming check.
    int seen_a = 0, seen_b = 0;

    always @(negedge clk) begin
        bit       hv, hs;
        bit [7:0] hd;
        hv = (mq.size() > 0);
        hs = hv ? mq[0][8] : 1'b0;
        hd = hv ? mq[0][7:0] : 8'h00;
        chk("m_in_ready", in_ready, (mq.size() != DEPTH));
        chk("m_level",    level,    mq.size());
        chk("m_a_valid",  a_valid,  hv && !hs);
        chk("m_a_data",   a_data,   (hv && !hs) ? hd : 8'h00);
        chk("m_b_valid",  b_valid,  hv && hs);
        chk("m_b_data",   b_data,   (hv && hs) ? hd : 8'h00);
        if (a_valid && a_ready) seen_a++;
        if (b_valid && b_ready) seen_b++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 12 && level != 0; k++) tick();
        chk(name, level, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_level", level, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valids", {a_valid, b_valid}, 2'b00);

        // Single char to A, visible the cycle after acceptance only.
        a_ready = 1; b_ready = 1;
        in_valid = 1; in_sel = DEST_A; in_data = 8'h48;
        chk("t2_no_bypass", a_valid, 0);
        tick();
        in_valid = 0;
        chk("t2_a_valid", a_valid, 1);
        chk("t2_a_data", a_data, 8'h48);
        chk("t2_b_valid", b_valid, 0);
        tick();
        chk("t2_a_gone", a_valid, 0);
        chk("t2_level", level, 0);

        // Fill with consumers stalled; 5th char is held by the core.
        a_ready = 0; b_ready = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_sel = i[0]; in_data = 8'h30 + 8'(i);
            tick();
        end
        chk("t3_full_level", level, 4);
        chk("t3_in_ready", in_ready, 0);
        in_sel = 0; in_data = 8'h34;
        tick(); tick();
        chk("t3_held_level", level, 4);
        chk("t3_head_a", a_data, 8'h30);
        a_ready = 1; b_ready = 1;
        tick();
        chk("t3_no_passthru", level, 3);
        chk("t3_head_b", b_data, 8'h31);
        tick();
        in_valid = 0;
        chk("t3_5th_in", level, 3);
        drain("t3_drain");

        // Head-of-line block: B head stalls following A entry.
        a_ready = 1; b_ready = 0;
        in_valid = 1; in_sel = DEST_B; in_data = 8'h58;
        tick();
        in_sel = DEST_A; in_data = 8'h59;
        tick();
        in_valid = 0;
        tick(); tick();
        chk("t4_a_blocked", a_valid, 0);
        chk("t4_b_head", b_data, 8'h58);
        chk("t4_level", level, 2);
        b_ready = 1;
        tick();
        chk("t4_y_on_a", a_data, 8'h59);
        chk("t4_b_done", b_valid, 0);
        tick();
        chk("t4_empty", level, 0);

        // Steady alternating stream with both consumers ready.
        seen_a = 0; seen_b = 0;
        a_ready = 1; b_ready = 1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1; in_sel = i[0]; in_data = 8'h41 + 8'(i);
            tick();
            if (level > 1) chk("t5_level_le1", level, 1);
        end
        in_valid = 0;
        drain("t5_drain");
        @(negedge clk);
        chk("t5_seen_a", seen_a, 10);
        chk("t5_seen_b", seen_b, 10);

`ifdef DEMUX_STATS_EN
        chk("t6_cnt_a", cnt_a, m_pop_a);
        chk("t6_cnt_b", cnt_b, m_pop_b);
        chk("t6_drop", drop_cnt, m_drop);
        chk("t6_drop_lit", drop_cnt, 3);
`endif

        // Reset mid-stream with three buffered chars.
        #1;
        a_ready = 0; b_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_sel = i[0]; in_data = 8'h60 + 8'(i);
            tick();
        end
        in_valid = 0;
        chk("t1_pre_level", level, 3);
        #2 rst = 1'b1;
        #1;
        chk("t1_level", level, 0);
        chk("t1_in_ready", in_ready, 1);
        chk("t1_outs", {a_valid, b_valid, a_data, b_data}, 18'h0);
        tick();
        rst = 1'b0;
        a_ready = 1; b_ready = 1;
        tick();
        chk("t1_post_level", level, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
